// File: rtl/order_ingress_sched_pkg.sv
// Shared order/trade word layout and scheduler state encodings for the order ingress path.
package order_ingress_sched_pkg;

    localparam int ORDER_W   = 32;
    localparam int PRICE_MSB = 31;
    localparam int PRICE_LSB = 16;
    localparam int SIDE_BIT  = 15;
    localparam int ID_BIT    = 14;
    localparam int QTY_MSB   = 13;
    localparam int QTY_LSB   = 0;
    localparam int QTY_W     = QTY_MSB - QTY_LSB + 1;

    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [ST_W-1:0] ST_ISSUE     = 3'd1;
    localparam logic [ST_W-1:0] ST_WAIT_ACK  = 3'd2;
    localparam logic [ST_W-1:0] ST_WAIT_DONE = 3'd3;
    localparam logic [ST_W-1:0] ST_GAP       = 3'd4;

endpackage

// File: rtl/order_ingress_sched_fifo.sv
// Per-channel order buffer: count-based full/empty, push ignored when full, pop ignored when empty.
module order_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/order_ingress_sched.sv
// Multi-channel order ingress: per-channel FIFOs, round-robin pick, paced single-order handshake
// to the matching engine, plus free-running trade/order statistics.
module order_ingress_sched
    import order_ingress_sched_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         ch_valid,
    input  logic [NUM_CH*ORDER_W-1:0] ch_data,
    output logic [NUM_CH-1:0]         ch_ready,
    output logic                      eng_valid,
    output logic [ORDER_W-1:0]        eng_data,
    input  logic                      eng_busy,
    input  logic                      trade_valid,
    input  logic [ORDER_W-1:0]        trade_info,
    output logic [31:0]               stat_sent,
    output logic [31:0]               stat_trades,
    output logic [31:0]               stat_trade_qty,
    output logic [31:0]               stat_dropped,
    output logic                      err_timeout
);

    localparam int unsigned NCH = NUM_CH;
    localparam int CW = $clog2(NUM_CH);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW:0]   NCH_W   = (CW+1)'(NUM_CH);
    localparam logic [CW:0]   LAST_CH = (CW+1)'(NUM_CH - 1);
    localparam logic [TW-1:0] TO_VAL  = TW'(ACK_TIMEOUT);

    logic [ST_W-1:0]    state;
    logic [CW-1:0]      rr_ptr;
    logic [CW-1:0]      grant_idx;
    logic [CW-1:0]      next_ptr;
    logic [CW:0]        cand;
    logic [TW-1:0]      timer;
    logic [ORDER_W-1:0] issue_q;
    logic [ORDER_W-1:0] head;
    logic [NUM_CH-1:0]  fifo_full;
    logic [NUM_CH-1:0]  fifo_empty;
    logic [NUM_CH-1:0]  fifo_pop;
    logic [ORDER_W-1:0] fifo_dout [NUM_CH];
    logic               any_ne;
    logic               pop_en;
    logic               unused_trade_bits;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        order_fifo #(
            .WIDTH (ORDER_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (ch_valid[i]),
            .din   (ch_data[ORDER_W*i +: ORDER_W]),
            .pop   (fifo_pop[i]),
            .dout  (fifo_dout[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i])
        );
    end

    assign ch_ready = ~fifo_full;

    // First non-empty channel at or after rr_ptr, wrapping.
    always_comb begin
        any_ne    = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            cand = {1'b0, rr_ptr} + (CW+1)'(k);
            if (cand >= NCH_W) cand = cand - NCH_W;
            if (!any_ne && !fifo_empty[cand[CW-1:0]]) begin
                any_ne    = 1'b1;
                grant_idx = cand[CW-1:0];
            end
        end
    end

    assign head     = fifo_dout[grant_idx];
    assign next_ptr = ({1'b0, grant_idx} == LAST_CH) ? '0 : grant_idx + CW'(1);
    assign pop_en   = (state == ST_IDLE) && !eng_busy && any_ne;
    assign fifo_pop = pop_en ? (NUM_CH'(1) << grant_idx) : '0;

    assign eng_valid = (state == ST_ISSUE);
    assign eng_data  = issue_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            timer        <= '0;
            issue_q      <= '0;
            stat_sent    <= '0;
            stat_dropped <= '0;
            err_timeout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop_en) begin
                        rr_ptr <= next_ptr;
                        // Zero-qty orders burn the slot but leave eng_data untouched.
                        if (head[QTY_MSB:QTY_LSB] == '0) begin
                            stat_dropped <= stat_dropped + 32'd1;
                        end else begin
                            issue_q <= head;
                            state   <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    stat_sent <= stat_sent + 32'd1;
                    timer     <= '0;
                    state     <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (eng_busy) begin
                        timer <= '0;
                        state <= ST_WAIT_DONE;
                    end else if (timer == TO_VAL) begin
                        timer       <= '0;
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!eng_busy) state <= ST_GAP;
                end
                ST_GAP:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_trades    <= '0;
            stat_trade_qty <= '0;
        end else if (trade_valid) begin
            stat_trades    <= stat_trades + 32'd1;
            stat_trade_qty <= stat_trade_qty + 32'(trade_info[QTY_MSB:QTY_LSB]);
        end
    end

    assign unused_trade_bits = ^trade_info[ORDER_W-1:QTY_MSB+1];

endmodule
